pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LAT, default 4: total EX-occupancy cycles of a multi-cycle op; legal range 2..16.
REQ-002 SHALL have parameter RW, default 5: register-index width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port id_rs, input, RW: source register A of the instruction in ID.
REQ-006 SHALL have port id_rt, input, RW: source register B of the instruction in ID.
REQ-007 SHALL have port id_uses_rt, input, 1: ID instruction reads id_rt.
REQ-008 SHALL have port ex_mem_read, input, 1: instruction in EX is a load.
REQ-009 SHALL have port ex_rt, input, RW: destination of the EX load.
REQ-010 SHALL have port id_branch_taken, input, 1: branch in ID resolved as taken.
REQ-011 SHALL have port id_mc_start, input, 1: ID instruction is a multi-cycle op.
REQ-012 SHALL have port mem_wait, input, 1: data memory not ready; freeze request.
REQ-013 SHALL have port pc_hold, output, 1: PC must not update.
REQ-014 SHALL have port ifid_hold, output, 1: drives IF/ID register hold.
REQ-015 SHALL have port if_flush, output, 1: drives IF/ID register flush (instruction zeroed).
REQ-016 SHALL have port idex_bubble, output, 1: ID/EX register loads a NOP.
REQ-017 SHALL have port busy, output, 1: state is not RUN.
REQ-018 SHALL have port stall_cnt, output, 32: stall-cycle performance counter.

Function
REQ-019 SHALL implement states RUN and MC_WAIT, plus a 4-bit down-counter mc_cnt.
REQ-020 SHALL define load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
REQ-021 SHALL generate all control outputs combinationally from the current state and inputs, with zero latency.
REQ-022 SHALL apply this priority: mem_wait, then MC_WAIT, then load_use, then id_mc_start, then id_branch_taken.
REQ-023 While mem_wait=1 (any state), SHALL drive pc_hold=1 and ifid_hold=1, if_flush=0, idex_bubble=0, and hold state and mc_cnt.
REQ-024 In MC_WAIT with mem_wait=0, SHALL drive pc_hold=1, ifid_hold=1, idex_bubble=1, and decrement mc_cnt.
REQ-025 In MC_WAIT with mem_wait=0 and mc_cnt==1, SHALL return to RUN at the next edge.
REQ-026 In MC_WAIT, SHALL ignore id_branch_taken, load_use and id_mc_start.
REQ-027 In RUN with load_use=1, SHALL drive pc_hold=1, ifid_hold=1, idex_bubble=1 for that cycle only, state unchanged; a taken branch SHALL NOT flush that cycle.
REQ-028 In RUN with id_mc_start=1 and no load_use, SHALL let the op issue that cycle (no hold), go to MC_WAIT, and load mc_cnt=MC_LAT-1.
REQ-029 This SHALL give exactly MC_LAT-1 hold cycles per multi-cycle op, excluding mem_wait cycles.
REQ-030 In RUN with id_branch_taken=1 and no higher-priority condition, SHALL drive if_flush=1 for one cycle with pc_hold=0 and ifid_hold=0.
REQ-031 SHALL never assert if_flush together with ifid_hold.
REQ-032 SHALL never assert idex_bubble without pc_hold.

Reset
REQ-033 While rst_n=0 at a rising edge, SHALL set state=RUN, mc_cnt=0 and stall_cnt=0, including mid-MC_WAIT.
REQ-034 While rst_n=0, SHALL force pc_hold, ifid_hold, if_flush, idex_bubble and busy to 0.

Configuration
REQ-035 With macro PIPE_HAZARD_PERF_EN defined, stall_cnt SHALL increment on each edge where pc_hold=1 and rst_n=1, saturating at 32'hFFFFFFFF.
REQ-036 Without PIPE_HAZARD_PERF_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be inferred; port list unchanged.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> one cycle of pc_hold=ifid_hold=idex_bubble=1; if_flush=0; ex_rt=0 -> no stall.
REQ-038 Multi-cycle: MC_LAT=4, id_mc_start pulse -> busy=1 and hold/bubble for exactly 3 cycles, then RUN; stall_cnt=3 (PERF_EN).
REQ-039 Branch: id_branch_taken=1 in RUN -> if_flush=1 one cycle, pc_hold=0; same cycle with load_use=1 -> stall only, flush on the following cycle.
REQ-040 mem_wait=1 for 2 cycles in the middle of MC_WAIT -> hold extended to 5 total cycles, idex_bubble=0 during mem_wait, mc_cnt frozen.
REQ-041 rst_n=0 during MC_WAIT -> next cycle busy=0 and all outputs 0; stall_cnt=0.
REQ-042 PERF_EN with stall_cnt preset near saturation -> holds at FFFFFFFF; without the macro, stall_cnt stays 0 throughout.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble control for a 5-stage pipeline with multi-cycle EX ops.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   id_rs, id_rt      - ID source registers; id_uses_rt qualifies id_rt
//   ex_mem_read       - EX holds a load writing ex_rt
//   id_branch_taken   - taken branch resolved in ID
//   id_mc_start       - ID instruction is a multi-cycle op
//   mem_wait          - data memory not ready, freezes the pipe
//   pc_hold, ifid_hold, if_flush, idex_bubble - pipeline register controls
//   busy              - a multi-cycle op is occupying EX
//   stall_cnt         - stall-cycle counter (only with PIPE_HAZARD_PERF_EN, else 0)
// Optional feature macro: PIPE_HAZARD_PERF_EN
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_branch_taken,
    input  logic          id_mc_start,
    input  logic          mem_wait,
    output logic          pc_hold,
    output logic          ifid_hold,
    output logic          if_flush,
    output logic          idex_bubble,
    output logic          busy,
    output logic [31:0]   stall_cnt
);
    typedef enum logic {RUN, MC_WAIT} state_t;
    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);
    state_t     state_q, state_d;
    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic       load_use, in_mc;
    assign load_use = ex_mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign in_mc    = (state_q == MC_WAIT);
    // Outputs are masked by rst_n so nothing leaks out while reset is held.
    assign pc_hold     = rst_n & (mem_wait | in_mc | load_use);
    assign ifid_hold   = pc_hold;
    assign idex_bubble = rst_n & ~mem_wait & (in_mc | load_use);
    // An issuing multi-cycle op outranks a taken branch, so it suppresses the flush.
    assign if_flush    = rst_n & ~mem_wait & ~in_mc & ~load_use & ~id_mc_start & id_branch_taken;
    assign busy        = rst_n & in_mc;
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        if (!rst_n) begin
            state_d  = RUN;
            mc_cnt_d = '0;
        end else if (!mem_wait) begin
            if (in_mc) begin
                mc_cnt_d = mc_cnt_q - 4'd1;
                state_d  = (mc_cnt_q == 4'd1) ? RUN : MC_WAIT;
            end else if (!load_use && id_mc_start) begin
                state_d  = MC_WAIT;
                mc_cnt_d = MC_INIT;
            end
        end
    end
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        mc_cnt_q <= mc_cnt_d;
    end
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else if (pc_hold && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule
